// File: rtl/ysyx_24110015_axi_pkg.sv
// Shared types and constants for the AXI arbiter and crossbar.
package ysyx_24110015_axi_pkg;

   // Arbiter FSM states; StErr is only reachable with ARB_TIMEOUT_EN.
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRead  = 2'd1,
      StWrite = 2'd2,
      StErr   = 2'd3
   } arb_state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Round-robin successor of cur in [0, n), wrapping n-1 back to 0.
   function automatic logic [31:0] rr_next(input logic [31:0] cur, input logic [31:0] n);
      return (cur + 32'd1 >= n) ? 32'd0 : cur + 32'd1;
   endfunction

endpackage

// File: rtl/ysyx_24110015_rr_picker.sv
// Combinational round-robin priority picker: returns the first set bit of req
// at or after ptr, wrapping around. found is low when req is all zero.
module ysyx_24110015_rr_picker #(
   parameter int unsigned N     = 2,
   parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   logic [31:0]      sum;
   logic [IDX_W-1:0] cand;

   // Scan N candidates starting at ptr; the first requester wins.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      sum   = '0;
      cand  = '0;
      for (int unsigned k = 0; k < N; k++) begin
         sum = 32'(ptr) + k;
         if (sum >= N) begin
            sum = sum - N;
         end
         cand = IDX_W'(sum);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/ysyx_24110015_axi_rr_arbiter.sv
// N-to-1 AXI4 round-robin arbiter with whole-transaction locking.
// One transaction (read or write) is outstanding at a time; the granted master's
// channels are forwarded combinationally, all others see zeros.
// Optional: define ARB_TIMEOUT_EN to add a watchdog that answers a hung
// transaction with SLVERR via the StErr state.
module ysyx_24110015_axi_rr_arbiter
   import ysyx_24110015_axi_pkg::*;
#(
   parameter int unsigned NUM_MASTERS    = 2,
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned ID_W           = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   // upstream AR
   input  logic [NUM_MASTERS-1:0]               m_arvalid,
   output logic [NUM_MASTERS-1:0]               m_arready,
   input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]   m_araddr,
   input  logic [NUM_MASTERS-1:0][ID_W-1:0]     m_arid,
   input  logic [NUM_MASTERS-1:0][7:0]          m_arlen,
   input  logic [NUM_MASTERS-1:0][2:0]          m_arsize,
   input  logic [NUM_MASTERS-1:0][1:0]          m_arburst,
   // upstream R
   output logic [NUM_MASTERS-1:0]               m_rvalid,
   input  logic [NUM_MASTERS-1:0]               m_rready,
   output logic [NUM_MASTERS-1:0][DATA_W-1:0]   m_rdata,
   output logic [NUM_MASTERS-1:0][1:0]          m_rresp,
   output logic [NUM_MASTERS-1:0]               m_rlast,
   output logic [NUM_MASTERS-1:0][ID_W-1:0]     m_rid,
   // upstream AW
   input  logic [NUM_MASTERS-1:0]               m_awvalid,
   output logic [NUM_MASTERS-1:0]               m_awready,
   input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]   m_awaddr,
   input  logic [NUM_MASTERS-1:0][ID_W-1:0]     m_awid,
   input  logic [NUM_MASTERS-1:0][7:0]          m_awlen,
   input  logic [NUM_MASTERS-1:0][2:0]          m_awsize,
   input  logic [NUM_MASTERS-1:0][1:0]          m_awburst,
   // upstream W
   input  logic [NUM_MASTERS-1:0]               m_wvalid,
   output logic [NUM_MASTERS-1:0]               m_wready,
   input  logic [NUM_MASTERS-1:0][DATA_W-1:0]   m_wdata,
   input  logic [NUM_MASTERS-1:0][DATA_W/8-1:0] m_wstrb,
   input  logic [NUM_MASTERS-1:0]               m_wlast,
   // upstream B
   output logic [NUM_MASTERS-1:0]               m_bvalid,
   input  logic [NUM_MASTERS-1:0]               m_bready,
   output logic [NUM_MASTERS-1:0][1:0]          m_bresp,
   output logic [NUM_MASTERS-1:0][ID_W-1:0]     m_bid,
   // downstream AR
   output logic                                 s_arvalid,
   input  logic                                 s_arready,
   output logic [ADDR_W-1:0]                    s_araddr,
   output logic [ID_W-1:0]                      s_arid,
   output logic [7:0]                           s_arlen,
   output logic [2:0]                           s_arsize,
   output logic [1:0]                           s_arburst,
   // downstream R
   input  logic                                 s_rvalid,
   output logic                                 s_rready,
   input  logic [DATA_W-1:0]                    s_rdata,
   input  logic [1:0]                           s_rresp,
   input  logic                                 s_rlast,
   input  logic [ID_W-1:0]                      s_rid,
   // downstream AW
   output logic                                 s_awvalid,
   input  logic                                 s_awready,
   output logic [ADDR_W-1:0]                    s_awaddr,
   output logic [ID_W-1:0]                      s_awid,
   output logic [7:0]                           s_awlen,
   output logic [2:0]                           s_awsize,
   output logic [1:0]                           s_awburst,
   // downstream W
   output logic                                 s_wvalid,
   input  logic                                 s_wready,
   output logic [DATA_W-1:0]                    s_wdata,
   output logic [DATA_W/8-1:0]                  s_wstrb,
   output logic                                 s_wlast,
   // downstream B
   input  logic                                 s_bvalid,
   output logic                                 s_bready,
   input  logic [1:0]                           s_bresp,
   input  logic [ID_W-1:0]                      s_bid
);

   localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   arb_state_e             state_q, state_d;
   logic [IDX_W-1:0]       grant_q, grant_d;
   logic [IDX_W-1:0]       ptr_q, ptr_d;
   // Address/last-data already accepted downstream: stop forwarding so a master
   // re-raising valid cannot open a second outstanding transaction.
   logic                   ar_done_q, ar_done_d;
   logic                   aw_done_q, aw_done_d;
   logic                   w_done_q, w_done_d;

   logic [NUM_MASTERS-1:0] req;
   logic [IDX_W-1:0]       pick_idx;
   logic                   pick_found;
   logic [IDX_W-1:0]       ptr_after;
   logic                   ar_hs, aw_hs, w_last_hs, r_last_hs, b_hs;

   assign req       = m_arvalid | m_awvalid;
   assign ptr_after = IDX_W'(rr_next(32'(grant_q), NUM_MASTERS));
   assign ar_hs     = s_arvalid & s_arready;
   assign aw_hs     = s_awvalid & s_awready;
   assign w_last_hs = s_wvalid & s_wready & s_wlast;
   assign r_last_hs = s_rvalid & s_rready & s_rlast;
   assign b_hs      = s_bvalid & s_bready;

   ysyx_24110015_rr_picker #(
      .N     (NUM_MASTERS),
      .IDX_W (IDX_W)
   ) u_picker (
      .req   (req),
      .ptr   (ptr_q),
      .idx   (pick_idx),
      .found (pick_found)
   );

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             is_read_q, is_read_d;
   logic [ID_W-1:0]  id_q, id_d;
   logic             any_hs;
   logic             cnt_expire;

   assign any_hs = ar_hs | aw_hs | (s_rvalid & s_rready) | (s_wvalid & s_wready) | b_hs;
   assign cnt_expire = ((state_q == StRead) || (state_q == StWrite)) && !any_hs &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   // Watchdog counts stalled cycles; cleared in IDLE (so entry starts at 0) and on handshakes.
   always_comb begin
      cnt_d     = '0;
      is_read_d = is_read_q;
      id_d      = id_q;
      if (((state_q == StRead) || (state_q == StWrite)) && !any_hs) begin
         cnt_d = cnt_q + 1'b1;
      end
      if (state_q == StIdle && pick_found) begin
         is_read_d = m_arvalid[pick_idx];
         id_d      = m_arvalid[pick_idx] ? m_arid[pick_idx] : m_awid[pick_idx];
      end
   end

   // Watchdog and error-response context registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         is_read_q <= 1'b0;
         id_q      <= '0;
      end else begin
         cnt_q     <= cnt_d;
         is_read_q <= is_read_d;
         id_q      <= id_d;
      end
   end
`endif

   // Next-state: arbitrate in IDLE, lock until the transaction's final handshake.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      ptr_d     = ptr_q;
      ar_done_d = ar_done_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      unique case (state_q)
         StIdle: begin
            if (pick_found) begin
               grant_d   = pick_idx;
               state_d   = m_arvalid[pick_idx] ? StRead : StWrite;
               ar_done_d = 1'b0;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end
         end
         StRead: begin
            if (ar_hs) ar_done_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
            if (cnt_expire) state_d = StErr;
`endif
            if (r_last_hs) begin
               state_d = StIdle;
               ptr_d   = ptr_after;
            end
         end
         StWrite: begin
            if (aw_hs) aw_done_d = 1'b1;
            if (w_last_hs) w_done_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
            if (cnt_expire) state_d = StErr;
`endif
            if (b_hs) begin
               state_d = StIdle;
               ptr_d   = ptr_after;
            end
         end
`ifdef ARB_TIMEOUT_EN
         StErr: begin
            if (is_read_q ? m_rready[grant_q] : m_bready[grant_q]) begin
               state_d = StIdle;
               ptr_d   = ptr_after;
            end
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   // Arbiter state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         grant_q   <= '0;
         ptr_q     <= '0;
         ar_done_q <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         ptr_q     <= ptr_d;
         ar_done_q <= ar_done_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   // Channel routing: payloads follow the grant, handshakes only in the owning state.
   always_comb begin
      m_arready = '0;
      m_rvalid  = '0;
      m_rdata   = '0;
      m_rresp   = '0;
      m_rlast   = '0;
      m_rid     = '0;
      m_awready = '0;
      m_wready  = '0;
      m_bvalid  = '0;
      m_bresp   = '0;
      m_bid     = '0;
      s_arvalid = 1'b0;
      s_araddr  = m_araddr[grant_q];
      s_arid    = m_arid[grant_q];
      s_arlen   = m_arlen[grant_q];
      s_arsize  = m_arsize[grant_q];
      s_arburst = m_arburst[grant_q];
      s_rready  = 1'b0;
      s_awvalid = 1'b0;
      s_awaddr  = m_awaddr[grant_q];
      s_awid    = m_awid[grant_q];
      s_awlen   = m_awlen[grant_q];
      s_awsize  = m_awsize[grant_q];
      s_awburst = m_awburst[grant_q];
      s_wvalid  = 1'b0;
      s_wdata   = m_wdata[grant_q];
      s_wstrb   = m_wstrb[grant_q];
      s_wlast   = m_wlast[grant_q];
      s_bready  = 1'b0;
      unique case (state_q)
         StRead: begin
            s_arvalid          = m_arvalid[grant_q] & ~ar_done_q;
            m_arready[grant_q] = s_arready & ~ar_done_q;
            m_rvalid[grant_q]  = s_rvalid;
            m_rdata[grant_q]   = s_rdata;
            m_rresp[grant_q]   = s_rresp;
            m_rlast[grant_q]   = s_rlast;
            m_rid[grant_q]     = s_rid;
            s_rready           = m_rready[grant_q];
         end
         StWrite: begin
            s_awvalid          = m_awvalid[grant_q] & ~aw_done_q;
            m_awready[grant_q] = s_awready & ~aw_done_q;
            s_wvalid           = m_wvalid[grant_q] & ~w_done_q;
            m_wready[grant_q]  = s_wready & ~w_done_q;
            m_bvalid[grant_q]  = s_bvalid;
            m_bresp[grant_q]   = s_bresp;
            m_bid[grant_q]     = s_bid;
            s_bready           = m_bready[grant_q];
         end
`ifdef ARB_TIMEOUT_EN
         StErr: begin
            if (is_read_q) begin
               m_rvalid[grant_q] = 1'b1;
               m_rresp[grant_q]  = RESP_SLVERR;
               m_rlast[grant_q]  = 1'b1;
               m_rid[grant_q]    = id_q;
            end else begin
               m_bvalid[grant_q] = 1'b1;
               m_bresp[grant_q]  = RESP_SLVERR;
               m_bid[grant_q]    = id_q;
            end
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ysyx_24110015_axi_rr_arbiter.sv
// Directed bench for the round-robin AXI arbiter with three masters.
// The timeout sequence runs only when ARB_TIMEOUT_EN is defined.
module tb_ysyx_24110015_axi_rr_arbiter;
   import ysyx_24110015_axi_pkg::*;

   localparam int unsigned NM = 3;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned IW = 4;
   localparam int unsigned TO = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic [NM-1:0]             m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
   logic [NM-1:0][AW-1:0]     m_araddr, m_awaddr;
   logic [NM-1:0][IW-1:0]     m_arid, m_rid, m_awid, m_bid;
   logic [NM-1:0][7:0]        m_arlen, m_awlen;
   logic [NM-1:0][2:0]        m_arsize, m_awsize;
   logic [NM-1:0][1:0]        m_arburst, m_awburst, m_rresp, m_bresp;
   logic [NM-1:0][DW-1:0]     m_rdata, m_wdata;
   logic [NM-1:0]             m_awvalid, m_awready, m_wvalid, m_wready, m_wlast;
   logic [NM-1:0][DW/8-1:0]   m_wstrb;
   logic [NM-1:0]             m_bvalid, m_bready;

   logic            s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
   logic [AW-1:0]   s_araddr, s_awaddr;
   logic [IW-1:0]   s_arid, s_rid, s_awid, s_bid;
   logic [7:0]      s_arlen, s_awlen;
   logic [2:0]      s_arsize, s_awsize;
   logic [1:0]      s_arburst, s_awburst, s_rresp, s_bresp;
   logic [DW-1:0]   s_rdata, s_wdata;
   logic            s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
   logic [DW/8-1:0] s_wstrb;

   ysyx_24110015_axi_rr_arbiter #(
      .NUM_MASTERS    (NM),
      .ADDR_W         (AW),
      .DATA_W         (DW),
      .ID_W           (IW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .m_arvalid (m_arvalid), .m_arready (m_arready), .m_araddr  (m_araddr),
      .m_arid    (m_arid),    .m_arlen   (m_arlen),   .m_arsize  (m_arsize),
      .m_arburst (m_arburst),
      .m_rvalid  (m_rvalid),  .m_rready  (m_rready),  .m_rdata   (m_rdata),
      .m_rresp   (m_rresp),   .m_rlast   (m_rlast),   .m_rid     (m_rid),
      .m_awvalid (m_awvalid), .m_awready (m_awready), .m_awaddr  (m_awaddr),
      .m_awid    (m_awid),    .m_awlen   (m_awlen),   .m_awsize  (m_awsize),
      .m_awburst (m_awburst),
      .m_wvalid  (m_wvalid),  .m_wready  (m_wready),  .m_wdata   (m_wdata),
      .m_wstrb   (m_wstrb),   .m_wlast   (m_wlast),
      .m_bvalid  (m_bvalid),  .m_bready  (m_bready),  .m_bresp   (m_bresp),
      .m_bid     (m_bid),
      .s_arvalid (s_arvalid), .s_arready (s_arready), .s_araddr  (s_araddr),
      .s_arid    (s_arid),    .s_arlen   (s_arlen),   .s_arsize  (s_arsize),
      .s_arburst (s_arburst),
      .s_rvalid  (s_rvalid),  .s_rready  (s_rready),  .s_rdata   (s_rdata),
      .s_rresp   (s_rresp),   .s_rlast   (s_rlast),   .s_rid     (s_rid),
      .s_awvalid (s_awvalid), .s_awready (s_awready), .s_awaddr  (s_awaddr),
      .s_awid    (s_awid),    .s_awlen   (s_awlen),   .s_awsize  (s_awsize),
      .s_awburst (s_awburst),
      .s_wvalid  (s_wvalid),  .s_wready  (s_wready),  .s_wdata   (s_wdata),
      .s_wstrb   (s_wstrb),   .s_wlast   (s_wlast),
      .s_bvalid  (s_bvalid),  .s_bready  (s_bready),  .s_bresp   (s_bresp),
      .s_bid     (s_bid)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [2:0] arv;
      logic [2:0] awv;
      logic       srv;
      logic       srl;
      logic       sbv;
      logic       e_sarv;
      logic       e_sawv;
      logic [2:0] e_marr;
      logic [2:0] e_mawr;
      logic [2:0] e_mrv;
      logic [2:0] e_mbv;
   } vec_t;

   vec_t tbl[19];

   // Global safety net in case the design stops making progress.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      // arv awv srv srl sbv | sarv sawv marr mawr mrv mbv
      tbl[0]  = '{3'b111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000};
      tbl[1]  = '{3'b111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 3'b000, 3'b000, 3'b000};
      tbl[2]  = '{3'b110, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b001, 3'b000};
      tbl[3]  = '{3'b111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000};
      tbl[4]  = '{3'b111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 3'b000, 3'b000, 3'b000};
      tbl[5]  = '{3'b101, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b010, 3'b000};
      tbl[6]  = '{3'b111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000};
      tbl[7]  = '{3'b111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 3'b000, 3'b000, 3'b000};
      tbl[8]  = '{3'b011, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b100, 3'b000};
      tbl[9]  = '{3'b111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000};
      tbl[10] = '{3'b111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 3'b000, 3'b000, 3'b000};
      tbl[11] = '{3'b110, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b001, 3'b000};
      tbl[12] = '{3'b100, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000};
      tbl[13] = '{3'b100, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 3'b000, 3'b000, 3'b000};
      tbl[14] = '{3'b000, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b100, 3'b000};
      tbl[15] = '{3'b000, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000};
      tbl[16] = '{3'b000, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b001, 3'b000, 3'b000};
      tbl[17] = '{3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b001};
      tbl[18] = '{3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000};

      m_arvalid = '0; m_awvalid = '0; m_wvalid = '0; m_wlast = '0;
      m_rready = '1;  m_bready = '1;
      m_arlen = '0;   m_awlen = '0;   m_arsize = '0; m_awsize = '0;
      m_arburst = '0; m_awburst = '0; m_wdata = '0;  m_wstrb = '0;
      for (int i = 0; i < NM; i++) begin
         m_araddr[i] = 32'h8000_0000 + 32'(i) * 32'h1000;
         m_awaddr[i] = 32'h8000_0040 + 32'(i) * 32'h1000;
         m_arid[i]   = IW'(i + 1);
         m_awid[i]   = IW'(i + 5);
      end
      s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
      s_rvalid = 1'b0;  s_rlast = 1'b0;   s_rdata = '0; s_rresp = RESP_OKAY; s_rid = '0;
      s_bvalid = 1'b0;  s_bresp = RESP_OKAY; s_bid = '0;

      // Reset state: nothing forwarded even with requests pending.
      m_arvalid = 3'b111;
      #2;
      chk("rst s_arvalid", s_arvalid, 0);
      chk("rst m_arready", m_arready, 0);
      chk("rst s_rready", s_rready, 0);
      chk("rst s_bready", s_bready, 0);
      chk("rst m_rvalid", m_rvalid, 0);
      nxt();
      nxt();
      rst_n = 1'b1;

      // Cycle-by-cycle round robin table: grants 0,1,2,0 then skip-empty and write.
      for (int i = 0; i < 19; i++) begin
         m_arvalid = tbl[i].arv;
         m_awvalid = tbl[i].awv;
         s_rvalid  = tbl[i].srv;
         s_rlast   = tbl[i].srl;
         s_bvalid  = tbl[i].sbv;
         #2;
         chk($sformatf("vec%0d s_arvalid", i), s_arvalid, tbl[i].e_sarv);
         chk($sformatf("vec%0d s_awvalid", i), s_awvalid, tbl[i].e_sawv);
         chk($sformatf("vec%0d m_arready", i), m_arready, tbl[i].e_marr);
         chk($sformatf("vec%0d m_awready", i), m_awready, tbl[i].e_mawr);
         chk($sformatf("vec%0d m_rvalid", i), m_rvalid, tbl[i].e_mrv);
         chk($sformatf("vec%0d m_bvalid", i), m_bvalid, tbl[i].e_mbv);
         nxt();
      end
      s_rvalid = 1'b0; s_rlast = 1'b0; s_bvalid = 1'b0;

      // Single read from master 0: one-cycle arbitration latency, data forwarded.
      m_arvalid = 3'b001;
      m_arid[0] = 4'h3;
      #2 chk("A idle s_arvalid", s_arvalid, 0);
      nxt();
      #2;
      chk("A s_arvalid", s_arvalid, 1);
      chk("A s_araddr", s_araddr, 32'h8000_0000);
      chk("A s_arid", s_arid, 4'h3);
      chk("A m_arready", m_arready, 3'b001);
      nxt();
      m_arvalid = 3'b000;
      s_rvalid = 1'b1; s_rlast = 1'b1; s_rdata = 32'hDEAD_BEEF; s_rid = 4'h3;
      #2;
      chk("A m_rvalid", m_rvalid, 3'b001);
      chk("A m_rdata0", m_rdata[0], 32'hDEAD_BEEF);
      chk("A m_rdata1", m_rdata[1], 0);
      chk("A m_rid0", m_rid[0], 4'h3);
      chk("A m_rlast0", m_rlast[0], 1);
      nxt();
      s_rvalid = 1'b0; s_rlast = 1'b0;

      // Master 1 burst of 4 while master 0 waits: no switch before rlast.
      m_arvalid = 3'b011;
      m_arlen[1] = 8'd3;
      #2 chk("B idle s_arvalid", s_arvalid, 0);
      nxt();
      #2;
      chk("B m_arready", m_arready, 3'b010);
      chk("B s_araddr", s_araddr, 32'h8000_1000);
      chk("B s_arlen", s_arlen, 8'd3);
      nxt();
      m_arvalid = 3'b001;
      for (int b = 0; b < 4; b++) begin
         s_rvalid = 1'b1;
         s_rlast  = (b == 3);
         s_rdata  = 32'h100 + 32'(b);
         #2;
         chk($sformatf("B beat%0d m_rvalid", b), m_rvalid, 3'b010);
         chk($sformatf("B beat%0d m_arready", b), m_arready, 3'b000);
         chk($sformatf("B beat%0d m_rdata1", b), m_rdata[1], 32'h100 + 32'(b));
         nxt();
      end
      s_rvalid = 1'b0; s_rlast = 1'b0;
      #2 chk("B after s_arvalid", s_arvalid, 0);
      nxt();
      #2;
      chk("B m0 m_arready", m_arready, 3'b001);
      chk("B m0 s_araddr", s_araddr, 32'h8000_0000);
      nxt();
      m_arvalid = 3'b000; s_rvalid = 1'b1; s_rlast = 1'b1;
      #2 chk("B m0 m_rvalid", m_rvalid, 3'b001);
      nxt();
      s_rvalid = 1'b0; s_rlast = 1'b0;

      // W presented two cycles before AW, slave stalls W: wvalid held until accepted.
      m_wvalid = 3'b001; m_wdata[0] = 32'hCAFE_F00D; m_wstrb[0] = 4'hF; m_wlast[0] = 1'b1;
      s_wready = 1'b0; s_awready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         #2;
         chk($sformatf("C pre%0d s_wvalid", c), s_wvalid, 0);
         chk($sformatf("C pre%0d m_wready", c), m_wready, 0);
         nxt();
      end
      m_awvalid = 3'b001;
      #2 chk("C idle s_awvalid", s_awvalid, 0);
      nxt();
      for (int c = 0; c < 2; c++) begin
         #2;
         chk($sformatf("C st%0d s_wvalid", c), s_wvalid, 1);
         chk($sformatf("C st%0d s_awvalid", c), s_awvalid, 1);
         chk($sformatf("C st%0d m_wready", c), m_wready, 0);
         nxt();
      end
      s_wready = 1'b1; s_awready = 1'b1;
      #2;
      chk("C s_wdata", s_wdata, 32'hCAFE_F00D);
      chk("C s_awaddr", s_awaddr, 32'h8000_0040);
      chk("C m_wready", m_wready, 3'b001);
      chk("C m_awready", m_awready, 3'b001);
      nxt();
      m_wvalid = 3'b000; m_awvalid = 3'b000;
      s_bvalid = 1'b1; s_bresp = RESP_OKAY; s_bid = 4'h5;
      #2;
      chk("C m_bvalid", m_bvalid, 3'b001);
      chk("C m_bresp0", m_bresp[0], RESP_OKAY);
      chk("C m_bid0", m_bid[0], 4'h5);
      nxt();
      s_bvalid = 1'b0;

      // Master 2 with AR and AW together: read first, write on its next turn.
      m_arvalid = 3'b100; m_awvalid = 3'b100;
      nxt();
      #2;
      chk("D rd s_arvalid", s_arvalid, 1);
      chk("D rd s_awvalid", s_awvalid, 0);
      chk("D rd m_arready", m_arready, 3'b100);
      chk("D rd m_awready", m_awready, 3'b000);
      nxt();
      m_arvalid = 3'b010; s_rvalid = 1'b1; s_rlast = 1'b1;
      #2 chk("D rd m_rvalid", m_rvalid, 3'b100);
      nxt();
      s_rvalid = 1'b0; s_rlast = 1'b0;
      nxt();
      #2;
      chk("D m1 m_arready", m_arready, 3'b010);
      chk("D m1 s_awvalid", s_awvalid, 0);
      nxt();
      m_arvalid = 3'b000; s_rvalid = 1'b1; s_rlast = 1'b1;
      #2 chk("D m1 m_rvalid", m_rvalid, 3'b010);
      nxt();
      s_rvalid = 1'b0; s_rlast = 1'b0;
      nxt();
      #2;
      chk("D wr s_awvalid", s_awvalid, 1);
      chk("D wr s_awaddr", s_awaddr, 32'h8000_2040);
      chk("D wr m_awready", m_awready, 3'b100);
      nxt();
      m_awvalid = 3'b000; s_bvalid = 1'b1;
      #2 chk("D wr m_bvalid", m_bvalid, 3'b100);
      nxt();
      s_bvalid = 1'b0;

      // Reset in the middle of a stalled read; pointer must restart at 0.
      m_arvalid = 3'b001;
      nxt();
      nxt();
      m_arvalid = 3'b000; s_rvalid = 1'b1; s_rlast = 1'b1;
      nxt();
      s_rvalid = 1'b0; s_rlast = 1'b0;
      m_arvalid = 3'b010; s_arready = 1'b0;
      nxt();
      #2 chk("E stall s_arvalid", s_arvalid, 1);
      rst_n = 1'b0;
      #1;
      chk("E rst s_arvalid", s_arvalid, 0);
      chk("E rst s_rready", s_rready, 0);
      nxt();
      rst_n = 1'b1; s_arready = 1'b1;
      m_arvalid = 3'b011;
      #2 chk("E idle s_arvalid", s_arvalid, 0);
      nxt();
      #2;
      chk("E ptr0 m_arready", m_arready, 3'b001);
      chk("E ptr0 s_araddr", s_araddr, 32'h8000_0000);
      nxt();
      m_arvalid = 3'b010; s_rvalid = 1'b1; s_rlast = 1'b1;
      nxt();
      s_rvalid = 1'b0; s_rlast = 1'b0;
      nxt();
      #2 chk("E m1 m_arready", m_arready, 3'b010);
      nxt();
      m_arvalid = 3'b000; s_rvalid = 1'b1; s_rlast = 1'b1;
      nxt();
      s_rvalid = 1'b0; s_rlast = 1'b0;

`ifdef ARB_TIMEOUT_EN
      // Slave never accepts AR: after TO stalled cycles master 0 gets SLVERR.
      m_arvalid = 3'b001; s_arready = 1'b0;
      nxt();
      for (int k = 0; k < TO; k++) begin
         #2 chk($sformatf("F wait%0d s_arvalid", k), s_arvalid, 1);
         nxt();
      end
      m_arvalid = 3'b010;
      #2;
      chk("F err s_arvalid", s_arvalid, 0);
      chk("F err m_rvalid", m_rvalid, 3'b001);
      chk("F err m_rresp0", m_rresp[0], RESP_SLVERR);
      chk("F err m_rlast0", m_rlast[0], 1);
      chk("F err m_rid0", m_rid[0], 4'h3);
      nxt();
      s_arready = 1'b1;
      nxt();
      #2 chk("F next m_arready", m_arready, 3'b010);
      nxt();
      m_arvalid = 3'b000; s_rvalid = 1'b1; s_rlast = 1'b1;
      nxt();
      s_rvalid = 1'b0; s_rlast = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
